// File: rtl/cellrv32_package.sv
// Shared constants and types for the outbound event (XEVT) controller.
package cellrv32_package;

    // XEVT register window: four word registers
    localparam logic [31:0] xevt_base_c    = 32'hFFFF_F600;
    localparam int          xevt_size_c    = 16;
    localparam logic [31:0] xevt_enable_c  = xevt_base_c + 32'h0;
    localparam logic [31:0] xevt_mode_c    = xevt_base_c + 32'h4;
    localparam logic [31:0] xevt_trigger_c = xevt_base_c + 32'h8;
    localparam logic [31:0] xevt_done_c    = xevt_base_c + 32'hC;

    typedef enum logic {XEVT_CH_IDLE, XEVT_CH_ACTIVE} xevt_ch_state_t;

    // Mask covering the implemented channels
    function automatic logic [31:0] xevt_ch_mask(input int num_ch);
        logic [32:0] m;
        m = (33'd1 << num_ch) - 33'd1;
        return m[31:0];
    endfunction

endpackage

// File: rtl/cellrv32_xevt_ch.sv
// One outbound event channel: IDLE/ACTIVE FSM, pulse counter, ack synchronizer.
module cellrv32_xevt_ch
    import cellrv32_package::*;
#(
    parameter int XEVT_PULSE_LEN = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,      // effective enable (includes a same-cycle ENABLE write)
    input  logic mode_i,    // 0 = pulse, 1 = level handshake
    input  logic trig_i,
    input  logic ack_i,     // asynchronous acknowledge from the device
    output logic active_o,
    output logic done_o     // one cycle: transfer completes at the next edge
);

    xevt_ch_state_t state_q, state_d;
    logic [7:0]     cnt_q;
    logic           mode_q;
    logic [1:0]     sync_q;
    logic           start, finish;

    assign start  = trig_i && en_i;
    assign finish = mode_q ? sync_q[1] : (cnt_q == 8'd0);

    // Two-flop synchronizer for the device acknowledge
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], ack_i};
    end

    // Latch mode at trigger time and run the pulse down-counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= 8'd0;
            mode_q <= 1'b0;
        end else if (state_q == XEVT_CH_IDLE) begin
            if (start) begin
                cnt_q  <= 8'(XEVT_PULSE_LEN - 1);
                mode_q <= mode_i;
            end
        end else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= XEVT_CH_IDLE;
        else         state_q <= state_d;
    end

    // Next state: triggers only count from IDLE; disable aborts without completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            XEVT_CH_IDLE:   if (start) state_d = XEVT_CH_ACTIVE;
            XEVT_CH_ACTIVE: if (!en_i || finish) state_d = XEVT_CH_IDLE;
            default:        state_d = XEVT_CH_IDLE;
        endcase
    end

    // Outputs: line follows ACTIVE, completion only when not aborted
    always_comb begin
        active_o = (state_q == XEVT_CH_ACTIVE);
        done_o   = (state_q == XEVT_CH_ACTIVE) && en_i && finish;
    end

endmodule

// File: rtl/cellrv32_xevt.sv
// Outbound event controller: bus registers plus XEVT_NUM_CH event channels.
module cellrv32_xevt
    import cellrv32_package::*;
#(
    parameter int XEVT_NUM_CH    = 1,
    parameter int XEVT_PULSE_LEN = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic [31:0] xevt_o,
    input  logic [31:0] xevt_ack_i,
    output logic        cpu_irq_o
);

    localparam int          LO_C   = $clog2(xevt_size_c);
    localparam logic [31:0] MASK_C = xevt_ch_mask(XEVT_NUM_CH);

    generate
        if (XEVT_NUM_CH < 1 || XEVT_NUM_CH > 32)
            $error("XEVT_NUM_CH must be within 1..32");
        if (XEVT_PULSE_LEN < 1 || XEVT_PULSE_LEN > 255)
            $error("XEVT_PULSE_LEN must be within 1..255");
    endgenerate

    logic [31:0] enable_q, mode_q, done_q, rdata_q;
    logic [31:0] en_eff, trig, done_set, done_clr, active, rmux;
    logic        match, wr, rd, ack_q, irq_q;
    logic        unused_bits;

    assign match = (addr_i[31:LO_C] == xevt_base_c[31:LO_C]);
    assign wr    = match && wren_i;
    assign rd    = match && rden_i;

    assign unused_bits = ^{addr_i[1:0], data_i, xevt_ack_i};

    // Write decode; channels see an ENABLE write in the same cycle it lands
    always_comb begin
        en_eff   = (wr && addr_i[31:2] == xevt_enable_c[31:2]) ? (data_i & MASK_C) : enable_q;
        trig     = (wr && addr_i[31:2] == xevt_trigger_c[31:2]) ? (data_i & MASK_C) : 32'd0;
        done_clr = (wr && addr_i[31:2] == xevt_done_c[31:2]) ? data_i : 32'd0;
    end

    genvar i;
    generate
        for (i = 0; i < 32; i++) begin : g_ch
            if (i < XEVT_NUM_CH) begin : g_on
                cellrv32_xevt_ch #(.XEVT_PULSE_LEN(XEVT_PULSE_LEN)) u_ch (
                    .clk_i    (clk_i),
                    .rstn_i   (rstn_i),
                    .en_i     (en_eff[i]),
                    .mode_i   (mode_q[i]),
                    .trig_i   (trig[i]),
                    .ack_i    (xevt_ack_i[i]),
                    .active_o (active[i]),
                    .done_o   (done_set[i])
                );
            end else begin : g_off
                assign active[i]   = 1'b0;
                assign done_set[i] = 1'b0;
            end
        end
    endgenerate

    // Control/status registers; hardware set wins over software clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            enable_q <= 32'd0;
            mode_q   <= 32'd0;
            done_q   <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            enable_q <= en_eff;
            if (wr && addr_i[31:2] == xevt_mode_c[31:2]) mode_q <= data_i & MASK_C;
            done_q   <= (done_q & ~done_clr) | done_set;
            irq_q    <= |(done_set & ~done_q);
        end
    end

    // Read mux
    always_comb begin
        rmux = 32'd0;
        case (addr_i[LO_C-1:2])
            xevt_enable_c[LO_C-1:2]:  rmux = enable_q;
            xevt_mode_c[LO_C-1:2]:    rmux = mode_q;
            xevt_trigger_c[LO_C-1:2]: rmux = active;
            xevt_done_c[LO_C-1:2]:    rmux = done_q;
            default:                  rmux = 32'd0;
        endcase
    end

    // Bus response one cycle after access; data zero outside ack
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q   <= rd || wr;
            rdata_q <= rd ? rmux : 32'd0;
        end
    end

    assign ack_o     = ack_q;
    assign data_o    = rdata_q;
    assign xevt_o    = active;
    assign cpu_irq_o = irq_q;

endmodule

// File: doc/cellrv32_xevt.md
CELLRV32_XEVT -- requirements
Module: cellrv32_xevt

Interface
REQ-001 Parameter XEVT_NUM_CH, default 1, number of outbound event channels (1..32).
REQ-002 Parameter XEVT_PULSE_LEN, default 4, pulse-mode output high time in clock cycles (1..255).
REQ-003 clk_i  input  1  global clock, all state on rising edge.
REQ-004 rstn_i  input  1  global reset, asynchronous, active-low.
REQ-005 addr_i  input  32  bus access address.
REQ-006 rden_i  input  1  bus read enable.
REQ-007 wren_i  input  1  bus write enable.
REQ-008 data_i  input  32  bus write data.
REQ-009 data_o  output  32  bus read data.
REQ-010 ack_o  output  1  bus transfer acknowledge.
REQ-011 xevt_o  output  32  outbound interrupt/event lines to external devices.
REQ-012 xevt_ack_i  input  32  per-channel acknowledge from external devices, asynchronous.
REQ-013 cpu_irq_o  output  1  completion interrupt to CPU.

Function
REQ-014 Module SHALL respond only when addr_i[hi:lo] matches xevt_base_c window; word-aligned register offsets: 0x0 ENABLE (r/w), 0x4 MODE (r/w, 0=pulse, 1=level-handshake), 0x8 TRIGGER (write-1 starts channel; read returns per-channel active), 0xC DONE (read done flags; write-1 clears).
REQ-015 ack_o SHALL assert exactly one cycle after any accepted rden or wren; data_o SHALL be valid in that cycle and zero otherwise.
REQ-016 Bits at or above XEVT_NUM_CH SHALL read 0, ignore writes, and drive xevt_o low.
REQ-017 Each channel SHALL run FSM IDLE -> ACTIVE -> IDLE; xevt_o[i] high exactly while ACTIVE.
REQ-018 TRIGGER write bit i SHALL move channel i IDLE -> ACTIVE on the next edge only if ENABLE[i]=1; ignored if disabled or already ACTIVE.
REQ-019 Pulse mode: ACTIVE SHALL last exactly XEVT_PULSE_LEN cycles (8-bit down-counter), then IDLE with DONE[i] set.
REQ-020 Level mode: xevt_ack_i[i] SHALL pass a 2-FF synchronizer; ACTIVE SHALL end on the first cycle synchronized ack is high, then IDLE with DONE[i] set.
REQ-021 Clearing ENABLE[i] while ACTIVE SHALL abort: xevt_o[i] low next cycle, IDLE, DONE[i] not set.
REQ-022 MODE[i] SHALL be sampled at TRIGGER; MODE writes during ACTIVE SHALL not affect the running transfer.
REQ-023 Same-cycle DONE set by hardware and DONE write-1 clear SHALL leave DONE set.
REQ-024 cpu_irq_o SHALL be a single-cycle pulse in the cycle after any DONE bit transitions 0->1; simultaneous completions produce one pulse.
REQ-025 Re-trigger in the same cycle a channel returns to IDLE SHALL be ignored; software retriggers after observing DONE.

Reset
REQ-026 On rstn_i low: ENABLE, MODE, DONE, counters, synchronizers cleared; all FSMs IDLE; xevt_o, cpu_irq_o, ack_o, data_o = 0.
REQ-027 Reset asserted mid-ACTIVE SHALL drop xevt_o immediately (asynchronously) with no DONE.

Structure
REQ-028 xevt_base_c, xevt_size_c and the four register address constants SHALL reside in cellrv32_package.
REQ-029 Per-channel FSM, counter and synchronizer SHALL be sub-module cellrv32_xevt_ch, instantiated XEVT_NUM_CH times by generate.
REQ-030 Elaboration SHALL error if XEVT_NUM_CH outside 1..32 or XEVT_PULSE_LEN outside 1..255.

Verification
REQ-031 NUM_CH=4, PULSE_LEN=4: ENABLE=0x1, MODE=0, TRIGGER=0x1 -> xevt_o[0] high exactly 4 cycles, DONE=0x1, one cpu_irq_o pulse.
REQ-032 Level mode ch2: TRIGGER=0x4, xevt_ack_i[2] raised 10 cycles later -> xevt_o[2] falls 3 cycles after ack, DONE=0x4.
REQ-033 TRIGGER=0x2 with ENABLE=0x0 -> xevt_o stays 0, DONE=0, no cpu_irq_o.
REQ-034 Level ch1 ACTIVE, write ENABLE=0 -> xevt_o[1] low next cycle, DONE[1]=0.
REQ-035 Pulse-mode ch0/ch3 triggered together -> one cpu_irq_o pulse, DONE=0x9; write DONE=0x9 -> reads 0x0.
REQ-036 Assert rstn_i low mid-pulse -> xevt_o=0 immediately; all registers read 0 after release.
